// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcode, ALU code and control-bundle definitions
// Used by control_unit, cu_decode, the ALU and the datapath.
package cu_pkg;

    localparam int OPC_W   = 4;
    localparam int ALUOP_W = 3;

    localparam logic [OPC_W-1:0] OP_NOP   = 4'b0000;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'b0010;
    localparam logic [OPC_W-1:0] OP_AND   = 4'b0011;
    localparam logic [OPC_W-1:0] OP_OR    = 4'b0100;
    localparam logic [OPC_W-1:0] OP_XOR   = 4'b0101;
    localparam logic [OPC_W-1:0] OP_SLT   = 4'b0110;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'b0111;
    localparam logic [OPC_W-1:0] OP_STORE = 4'b1000;
    localparam logic [OPC_W-1:0] OP_ADDI  = 4'b1001;

    // 110 and 111 are reserved and never produced by the decoder.
    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic               reg_write;
        logic               alu_src;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic [ALUOP_W-1:0] alu_opn;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational opcode to control-bundle decoder
// Ports:
//   opcode - instruction opcode
//   ctrl   - decoded control bundle (undefined opcodes decode to NOP)
module cu_decode
    import cu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl
);

    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            OP_ADD: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_opn   = ALU_ADD;
            end
            OP_SUB: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_opn   = ALU_SUB;
            end
            OP_AND: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_opn   = ALU_AND;
            end
            OP_OR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_opn   = ALU_OR;
            end
            OP_XOR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_opn   = ALU_XOR;
            end
            OP_SLT: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_opn   = ALU_SLT;
            end
            OP_LOAD: begin
                // Address is rs + imm, so the ALU adds with the immediate operand.
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_opn    = ALU_ADD;
            end
            OP_STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_opn   = ALU_ADD;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_opn   = ALU_ADD;
            end
            default: ctrl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - registered main decoder for the 4-bit-opcode datapath
// Ports:
//   clk, rst   - clock and synchronous active-high reset (reset gives NOP controls)
//   opcode     - instruction opcode, sampled on each rising edge
//   reg_write, alu_src, mem_read, mem_write, mem_to_reg, alu_opn
//              - registered controls, valid one cycle after opcode is sampled
module control_unit
    import cu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode,
    output logic               reg_write,
    output logic               alu_src,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic [ALUOP_W-1:0] alu_opn
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    cu_decode u_decode (
        .opcode (opcode),
        .ctrl   (ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign reg_write  = ctrl_q.reg_write;
    assign alu_src    = ctrl_q.alu_src;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_opn    = ctrl_q.alu_opn;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'b0000;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [2:0] alu_opn;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed bundle: {rw, src, mrd, mwr, m2r, opn[2:0]}
    logic [7:0] obs;
    assign obs = {reg_write, alu_src, mem_read, mem_write, mem_to_reg, alu_opn};

    localparam logic [7:0] E_NOP   = 8'b00000_000;
    localparam logic [7:0] E_ADD   = 8'b10000_000;
    localparam logic [7:0] E_LOAD  = 8'b11101_000;
    localparam logic [7:0] E_STORE = 8'b01010_000;

    // Hand-written decode table, indexed by opcode.
    logic [7:0] exp_tab [16];

    control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .alu_opn    (alu_opn)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        opcode = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (obs !== E_NOP) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, E_NOP);
            end
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (obs !== E_NOP) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", obs, E_NOP);
        end
    endtask

    task automatic test_add();
        opcode = 4'b0001;
        #4;
        n_checks++;
        if (obs !== E_NOP) begin
            n_fail++;
            $display("FAIL add_before_edge: got %b expected %b", obs, E_NOP);
        end
        tick();
        n_checks++;
        if (obs !== E_ADD) begin
            n_fail++;
            $display("FAIL add_after_edge: got %b expected %b", obs, E_ADD);
        end
    endtask

    task automatic test_back_to_back();
        opcode = 4'b0111;
        tick();
        n_checks++;
        if (obs !== E_LOAD) begin
            n_fail++;
            $display("FAIL b2b_load: got %b expected %b", obs, E_LOAD);
        end
        opcode = 4'b1000;
        tick();
        n_checks++;
        if (obs !== E_STORE) begin
            n_fail++;
            $display("FAIL b2b_store: got %b expected %b", obs, E_STORE);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] op;
        for (int i = 0; i < 16; i++) begin
            op     = 4'(i);
            opcode = op;
            tick();
            n_checks++;
            if (obs !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL sweep_op%b: got %b expected %b", op, obs, exp_tab[i]);
            end
            n_checks++;
            if (mem_read && mem_write) begin
                n_fail++;
                $display("FAIL inv_rd_wr op%b: got mrd=%b mwr=%b expected not both 1", op, mem_read, mem_write);
            end
            n_checks++;
            if (mem_to_reg && !mem_read) begin
                n_fail++;
                $display("FAIL inv_m2r op%b: got m2r=%b mrd=%b expected m2r only with mrd", op, mem_to_reg, mem_read);
            end
            n_checks++;
            if (mem_write && reg_write) begin
                n_fail++;
                $display("FAIL inv_wr_rw op%b: got mwr=%b rw=%b expected rw=0 when mwr=1", op, mem_write, reg_write);
            end
        end
    endtask

    task automatic test_reset_mid();
        opcode = 4'b0111;
        tick();
        n_checks++;
        if (obs !== E_LOAD) begin
            n_fail++;
            $display("FAIL mid_pre: got %b expected %b", obs, E_LOAD);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (obs !== E_NOP) begin
            n_fail++;
            $display("FAIL mid_reset: got %b expected %b", obs, E_NOP);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (obs !== E_LOAD) begin
            n_fail++;
            $display("FAIL mid_recover: got %b expected %b", obs, E_LOAD);
        end
    endtask

    task automatic test_glitch();
        // Start from STORE so ADD is distinguishable.
        opcode = 4'b1000;
        tick();
        opcode = 4'b0001;
        #2 opcode = 4'b1000;
        #2 opcode = 4'b0001;
        #2;
        n_checks++;
        if (obs !== E_STORE) begin
            n_fail++;
            $display("FAIL glitch_hold: got %b expected %b", obs, E_STORE);
        end
        tick();
        n_checks++;
        if (obs !== E_ADD) begin
            n_fail++;
            $display("FAIL glitch_add: got %b expected %b", obs, E_ADD);
        end
        opcode = 4'b1000;
        #2 opcode = 4'b0001;
        #2 opcode = 4'b1000;
        tick();
        n_checks++;
        if (obs !== E_STORE) begin
            n_fail++;
            $display("FAIL glitch_store: got %b expected %b", obs, E_STORE);
        end
    endtask

    initial begin
        exp_tab[0]  = 8'b00000_000;
        exp_tab[1]  = 8'b10000_000;
        exp_tab[2]  = 8'b10000_001;
        exp_tab[3]  = 8'b10000_010;
        exp_tab[4]  = 8'b10000_011;
        exp_tab[5]  = 8'b10000_100;
        exp_tab[6]  = 8'b10000_101;
        exp_tab[7]  = 8'b11101_000;
        exp_tab[8]  = 8'b01010_000;
        exp_tab[9]  = 8'b11000_000;
        for (int i = 10; i < 16; i++) exp_tab[i] = 8'b00000_000;

        test_reset();
        test_add();
        test_back_to_back();
        test_sweep();
        test_reset_mid();
        test_glitch();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
